// File: rtl/prod_arbiter.sv
`default_nettype none
// ============================================================================
// prod_arbiter: arbitrates Fibonacci/Timer producers onto the shared buffer,
// tracks occupancy with credits. Optional: PROD_ARB_UNDERFLOW_CHK_EN (err).
// Revision: 1.0
// ============================================================================
module prod_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_data,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_data,
  input  logic              rd_ack,
  input  logic              cons_busy,
  output logic              f_en,
  output logic              t_en,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  occ,
  output logic [2:0]        state,
  output logic [5:0]        led,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMM_F    = 3'd1,
    WAIT_F    = 3'd2,
    COMM_T    = 3'd3,
    WAIT_T    = 3'd4,
    BUF_EMPTY = 3'd5
  } state_t;

  state_t st;
  logic   full;
  logic   empty;
  logic   rd_acc;

  assign full    = (occ == CNT_W'(BUF_DEPTH));
  assign empty   = (occ == '0);
  assign rd_acc  = rd_ack && !empty;
  assign f_en    = (st == COMM_F) && !full;
  assign t_en    = (st == COMM_T) && !full;
  assign wr_en   = (f_en && f_valid) || (t_en && t_valid);
  assign wr_data = (st == COMM_F) ? f_data : t_data;
  assign state   = st;
  assign led     = 6'b000001 << st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      occ <= '0;
    end else begin
      if (wr_en && !rd_acc)
        occ <= occ + 1'b1;
      else if (rd_acc && !wr_en)
        occ <= occ - 1'b1;

      case (st)
        IDLE: begin
          if (start_f)      st <= COMM_F;
          else if (start_t) st <= COMM_T;
        end
        COMM_F: begin
          if (stop)      st <= BUF_EMPTY;
          else if (full) st <= WAIT_F;
        end
        WAIT_F: begin
          if (stop)       st <= BUF_EMPTY;
          else if (!full) st <= COMM_F;
        end
        COMM_T: begin
          if (stop)      st <= BUF_EMPTY;
          else if (full) st <= WAIT_T;
        end
        WAIT_T: begin
          if (stop)       st <= BUF_EMPTY;
          else if (!full) st <= COMM_T;
        end
        BUF_EMPTY: begin
          // Return to idle only once the consumer has nothing left to show.
          if (empty && !cons_busy) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef PROD_ARB_UNDERFLOW_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (rd_ack && empty)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prod_arbiter.sv
`default_nettype none
// Testbench for prod_arbiter: scenario tasks with a write-data scoreboard.
module tb_prod_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_f, start_t, stop;
  logic        f_valid, t_valid;
  logic [15:0] f_data, t_data;
  logic        rd_ack, cons_busy;
  logic        f_en, t_en, wr_en;
  logic [15:0] wr_data;
  logic [3:0]  occ;
  logic [2:0]  state;
  logic [5:0]  led;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  prod_arbiter #(.DATA_W(16), .BUF_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop(stop),
    .f_valid(f_valid), .f_data(f_data), .t_valid(t_valid), .t_data(t_data),
    .rd_ack(rd_ack), .cons_busy(cons_busy), .f_en(f_en), .t_en(t_en),
    .wr_en(wr_en), .wr_data(wr_data), .occ(occ), .state(state), .led(led),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_f = 0; start_t = 0; stop = 0; f_valid = 0; t_valid = 0;
    f_data = '0; t_data = '0; rd_ack = 0; cons_busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    checks++;
    if (state !== 3'd0 || occ !== 4'd0 || led !== 6'b000001 || err !== 1'b0 ||
        f_en !== 1'b0 || t_en !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d occ=%0d led=%b err=%b f_en=%b t_en=%b wr_en=%b required 0 0 000001 0 0 0 0",
               state, occ, led, err, f_en, t_en, wr_en);
    end
    tick();
    rst = 0;
    tick();
  endtask

  // Fill to full with Fibonacci words, then expect WAIT_F.
  task automatic test_fill();
    logic [15:0] a, b, n;
    do_reset();
    start_f = 1; tick(); start_f = 0;
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL fill_start: state=%0d required 1", state); end
    a = 0; b = 1;
    f_valid = 1;
    for (int i = 0; i < 8; i++) begin
      f_data = a;
      exp_q.push_back(a);
      n = a + b; a = b; b = n;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1) begin
        errors++; $display("FAIL fill_wr_en[%0d]: wr_en=%b required 1", i, wr_en);
        void'(exp_q.pop_front());
      end else begin
        exp_w = exp_q.pop_front();
        if (wr_data !== exp_w) begin errors++; $display("FAIL fill_data[%0d]: wr_data=%0d required %0d", i, wr_data, exp_w); end
      end
      tick();
    end
    f_data = a;
    checks++;
    if (occ !== 4'd8 || f_en !== 1'b0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL fill_full: occ=%0d f_en=%b wr_en=%b required 8 0 0", occ, f_en, wr_en);
    end
    tick();
    checks++;
    if (state !== 3'd2 || led !== 6'b000100 || f_en !== 1'b0 || occ !== 4'd8) begin
      errors++; $display("FAIL fill_wait: state=%0d led=%b f_en=%b occ=%0d required 2 000100 0 8", state, led, f_en, occ);
    end
  endtask

  // Continues from WAIT_F with occ=8.
  task automatic test_refill();
    f_valid = 1; f_data = 16'd21;
    rd_ack = 1; tick(); rd_ack = 0;
    checks++;
    if (occ !== 4'd7 || state !== 3'd2) begin errors++; $display("FAIL refill_pop: occ=%0d state=%0d required 7 2", occ, state); end
    exp_q.push_back(16'd21);
    tick();
    checks++;
    if (state !== 3'd1 || f_en !== 1'b1) begin errors++; $display("FAIL refill_resume: state=%0d f_en=%b required 1 1", state, f_en); end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++; $display("FAIL refill_wr_en: wr_en=%b required 1", wr_en);
      void'(exp_q.pop_front());
    end else begin
      exp_w = exp_q.pop_front();
      if (wr_data !== exp_w) begin errors++; $display("FAIL refill_data: wr_data=%0d required %0d", wr_data, exp_w); end
    end
    tick();
    f_valid = 0;
    checks++;
    if (occ !== 4'd8) begin errors++; $display("FAIL refill_occ: occ=%0d required 8", occ); end
  endtask

  task automatic test_mid_reset();
    rst = 1;
    #1;
    checks++;
    if (state !== 3'd0 || occ !== 4'd0 || led !== 6'b000001) begin
      errors++; $display("FAIL mid_reset: state=%0d occ=%0d led=%b required 0 0 000001", state, occ, led);
    end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_stop_drain();
    do_reset();
    start_t = 1; tick(); start_t = 0;
    t_valid = 1;
    for (int i = 0; i < 3; i++) begin
      t_data = 16'h100 + 16'(i);
      exp_q.push_back(16'h100 + 16'(i));
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1) begin
        errors++; $display("FAIL timer_wr_en[%0d]: wr_en=%b required 1", i, wr_en);
        void'(exp_q.pop_front());
      end else begin
        exp_w = exp_q.pop_front();
        if (wr_data !== exp_w) begin errors++; $display("FAIL timer_data[%0d]: wr_data=%h required %h", i, wr_data, exp_w); end
      end
      tick();
    end
    t_valid = 0;
    checks++;
    if (occ !== 4'd3 || state !== 3'd3) begin errors++; $display("FAIL timer_occ: occ=%0d state=%0d required 3 3", occ, state); end
    stop = 1; cons_busy = 1; tick(); stop = 0;
    t_valid = 1;
    @(negedge clk);
    checks++;
    if (state !== 3'd5 || t_en !== 1'b0 || wr_en !== 1'b0 || led !== 6'b100000) begin
      errors++; $display("FAIL drain_enter: state=%0d t_en=%b wr_en=%b led=%b required 5 0 0 100000", state, t_en, wr_en, led);
    end
    tick();
    for (int k = 2; k >= 0; k--) begin
      rd_ack = 1; tick();
      checks++;
      if (occ !== 4'(k) || wr_en !== 1'b0) begin errors++; $display("FAIL drain_occ: occ=%0d wr_en=%b required %0d 0", occ, wr_en, k); end
    end
    rd_ack = 0; cons_busy = 0; t_valid = 0;
    checks++;
    if (state !== 3'd5) begin errors++; $display("FAIL drain_hold: state=%0d required 5", state); end
    tick();
    checks++;
    if (state !== 3'd0 || led !== 6'b000001) begin errors++; $display("FAIL drain_idle: state=%0d led=%b required 0 000001", state, led); end
  endtask

  task automatic test_both_starts();
    do_reset();
    start_f = 1; start_t = 1; tick(); start_f = 0; start_t = 0;
    checks++;
    if (state !== 3'd1 || t_en !== 1'b0 || f_en !== 1'b1) begin
      errors++; $display("FAIL both_starts: state=%0d t_en=%b f_en=%b required 1 0 1", state, t_en, f_en);
    end
  endtask

  // Continues from COMM_F at occ=0.
  task automatic test_back_to_back();
    f_valid = 1;
    for (int i = 0; i < 5; i++) begin
      f_data = 16'(i + 40);
      exp_q.push_back(16'(i + 40));
      @(negedge clk);
      if (wr_en === 1'b1) void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (occ !== 4'd5 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_fill: occ=%0d pending=%0d required 5 0", occ, exp_q.size());
      exp_q.delete();
    end
    f_data = 16'hBEEF; exp_q.push_back(16'hBEEF);
    rd_ack = 1; start_t = 1;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++; $display("FAIL b2b_wr_en: wr_en=%b required 1", wr_en);
      void'(exp_q.pop_front());
    end else begin
      exp_w = exp_q.pop_front();
      if (wr_data !== exp_w) begin errors++; $display("FAIL b2b_data: wr_data=%h required %h", wr_data, exp_w); end
    end
    tick();
    rd_ack = 0; start_t = 0; f_valid = 0;
    checks++;
    if (occ !== 4'd5 || state !== 3'd1 || t_en !== 1'b0) begin
      errors++; $display("FAIL b2b_same: occ=%0d state=%0d t_en=%b required 5 1 0", occ, state, t_en);
    end
  endtask

  task automatic test_underflow();
    logic exp_err;
`ifdef PROD_ARB_UNDERFLOW_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    rd_ack = 1; tick(); rd_ack = 0;
    checks++;
    if (occ !== 4'd0 || err !== exp_err) begin
      errors++; $display("FAIL underflow: occ=%0d err=%b required 0 %b", occ, err, exp_err);
    end
    start_f = 1; tick(); start_f = 0; tick(); tick();
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL underflow_sticky: err=%b required %b", err, exp_err); end
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL underflow_clear: err=%b required 0", err); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_fill();
    test_refill();
    test_mid_reset();
    test_stop_drain();
    test_both_starts();
    test_back_to_back();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/prod_arbiter.md
Name: prod_arbiter

Overview:
- Sequencer and arbiter between the two data producers (Fibonacci, Timer) and the shared producer-to-consumer buffer.
- Decides which producer owns the buffer write port and gates its enable.
- Tracks buffer occupancy through a credit counter, so a full buffer pauses the producer and a stop drains the buffer before returning to idle.
- Sits between the edge-detected push-buttons and the buffer/consumer datapath; its state drives the status LEDs.

Parameters:
- DATA_W, 16, width of producer and buffer data words.
- BUF_DEPTH, 8, number of buffer entries; full when occupancy == BUF_DEPTH.
- CNT_W, 4, occupancy counter width; must satisfy 2**CNT_W > BUF_DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- start_f  in  1  one-cycle pulse (already edge-detected): start/resume Fibonacci.
- start_t  in  1  one-cycle pulse: start/resume Timer.
- stop  in  1  one-cycle pulse: stop production and drain.
- f_valid  in  1  Fibonacci word available this cycle.
- f_data  in  DATA_W  Fibonacci word.
- t_valid  in  1  Timer word available this cycle.
- t_data  in  DATA_W  Timer word.
- rd_ack  in  1  consumer popped one buffer entry this cycle.
- cons_busy  in  1  consumer still holds or shows a word.
- f_en  out  1  Fibonacci enable.
- t_en  out  1  Timer enable.
- wr_en  out  1  buffer write strobe.
- wr_data  out  DATA_W  buffer write data.
- occ  out  CNT_W  current buffer occupancy.
- state  out  3  encoded state.
- led  out  6  one-hot state, led[state] = 1.
- err  out  1  sticky underflow flag; only active with the optional feature.

Behaviour:
- State encoding: IDLE=0, COMM_F=1, WAIT_F=2, COMM_T=3, WAIT_T=4, BUF_EMPTY=5. Register updates on posedge clk.
- Reset: state=IDLE, occ=0, err=0, led=6'b000001. f_en, t_en and wr_en are 0.
- full = (occ == BUF_DEPTH); empty = (occ == 0). Both are decoded from the registered occ.
- f_en = (state==COMM_F) && !full. t_en = (state==COMM_T) && !full.
- wr_en = (f_en && f_valid) || (t_en && t_valid), combinational, zero latency.
- wr_data = f_data when state==COMM_F, otherwise t_data.
- Occupancy update:
  - wr_en only: occ+1.
  - accepted rd_ack only: occ-1.
  - both in the same cycle: occ unchanged.
  - rd_ack with empty is ignored; occ never underflows.
  - Overflow cannot occur, because enables drop when full.
- IDLE:
  - start_f goes to COMM_F.
  - else start_t goes to COMM_T.
  - start_f wins if both pulse together.
  - stop is ignored.
- COMM_F:
  - stop goes to BUF_EMPTY; stop has priority over full.
  - else full goes to WAIT_F.
  - start_t and start_f are ignored.
- WAIT_F:
  - stop goes to BUF_EMPTY.
  - else !full goes to COMM_F.
- COMM_T and WAIT_T: same rules as COMM_F and WAIT_F, with t in place of f.
- BUF_EMPTY:
  - Both enables are 0.
  - Goes to IDLE when empty && !cons_busy.
  - start pulses and stop are ignored.
- No direct switch between producers is allowed; a stop and drain must come first.
- rst asserted mid-operation: immediate return to the reset values; the buffer contents are considered lost.
- led and state are registered-state decodes, with no extra latency.

Optional Feature:
- Macro: PROD_ARB_UNDERFLOW_CHK_EN.
- Defined: err is set to 1 on any rd_ack while empty, and stays set until rst. Occupancy behaviour is unchanged.
- Undefined: err is tied to 0, and the underflow-detect logic is not synthesised.

Test Plan:
- Reset then start_f pulse; f_valid=1 with f_data=0,1,1,2,... and no rd_ack:
  - state goes 0→1.
  - wr_en is high for 8 cycles and occ reaches 8.
  - state=2 and f_en=0.
  - led=000100.
- From WAIT_F, one rd_ack pulse:
  - occ goes to 7 and state returns to 1 the next cycle.
  - f_en reasserts and one write refills occ to 8.
- In COMM_T with occ=3, assert stop with rd_ack pulses; cons_busy falls after the last pop:
  - state goes to 5, t_en=0 and no further wr_en.
  - occ counts down 3→0.
  - state=0 one cycle after empty && !cons_busy.
- start_f and start_t pulsed in the same cycle in IDLE → state=1; t_en stays 0.
- In COMM_F, wr_en and rd_ack in the same cycle at occ=5 → occ stays 5; a start_t pulse is ignored and state stays 1.
- With PROD_ARB_UNDERFLOW_CHK_EN defined, rd_ack at occ=0 → occ stays 0 and err=1 until rst. With the macro undefined → err stays 0.
